// File: rtl/block_output_vc_if.sv
// Crossbar-side write bus and link-side val/ret bus of one router output port.
interface block_output_vc_if #(
   parameter int DATA_W = 8,
   parameter int NUM_VC = 2
);
   localparam int VC_W = $clog2(NUM_VC);

   logic [DATA_W-1:0] Data_in;
   logic              wr_en;
   logic [VC_W-1:0]   vc_in;
   logic [NUM_VC-1:0] full;
   logic              ovf;
   logic [DATA_W-1:0] Data_out;
   logic [VC_W-1:0]   vc_out;
   logic              val;
   logic              ret;

   // Driver of writes and consumer of the link (crossbar + downstream router).
   modport master (
      output Data_in, wr_en, vc_in, ret,
      input  full, ovf, Data_out, vc_out, val
   );

   // The output port itself.
   modport slave (
      input  Data_in, wr_en, vc_in, ret,
      output full, ovf, Data_out, vc_out, val
   );
endinterface

// File: rtl/block_output_vc.sv
// NoC router output port: NUM_VC virtual-channel FIFOs, round-robin arbitrated
// onto a single registered val/ret output link.
module block_output_vc #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int NUM_VC = 2
) (
   input  logic                clk,
   input  logic                rst,
   block_output_vc_if.slave    bus
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem    [NUM_VC][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NUM_VC];
   logic [PTR_W-1:0]  rd_ptr [NUM_VC];
   logic [CNT_W-1:0]  count  [NUM_VC];

   logic [NUM_VC-1:0] full_vec;
   logic [NUM_VC-1:0] nonempty;
   logic [NUM_VC-1:0] push;
   logic [NUM_VC-1:0] pop;
   logic [VC_W-1:0]   rr;
   logic [VC_W-1:0]   grant;
   logic              load;

   logic [DATA_W-1:0] data_q;
   logic [VC_W-1:0]   vc_q;
   logic              val_q;
   logic              ovf_q;

   // Per-VC status and push/pop qualification; full comes from the registered count,
   // so a pop in the same cycle never frees room for a write.
   always_comb begin
      full_vec = '0;
      nonempty = '0;
      push     = '0;
      pop      = '0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
         full_vec[v] = (count[v] == CNT_W'(DEPTH));
         nonempty[v] = (count[v] != '0);
      end
      load = (!val_q || bus.ret) && (|nonempty);
      for (int unsigned v = 0; v < NUM_VC; v++) begin
         push[v] = bus.wr_en && (bus.vc_in == VC_W'(v)) && !full_vec[v];
         pop[v]  = load && (grant == VC_W'(v));
      end
   end

   // Round-robin grant: first non-empty VC searching rr+1, rr+2, ... modulo NUM_VC.
   always_comb begin
      automatic int unsigned idx;
      automatic logic        found;
      grant = rr;
      found = 1'b0;
      for (int unsigned i = 1; i <= NUM_VC; i++) begin
         idx = rr;
         idx = (idx + i) % NUM_VC;
         if (!found && nonempty[idx]) begin
            grant = VC_W'(idx);
            found = 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because counts gate every read.
   always_ff @(posedge clk) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
         if (push[v]) begin
            mem[v][wr_ptr[v]] <= bus.Data_in;
         end
      end
   end

   // FIFO pointers/counts, overflow flag, output link register and RR pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            count[v]  <= '0;
         end
         ovf_q  <= 1'b0;
         val_q  <= 1'b0;
         data_q <= '0;
         vc_q   <= '0;
         rr     <= VC_W'(NUM_VC - 1);
      end else begin
         for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (push[v]) begin
               wr_ptr[v] <= wr_ptr[v] + 1'b1;
            end
            if (pop[v]) begin
               rd_ptr[v] <= rd_ptr[v] + 1'b1;
            end
            case ({push[v], pop[v]})
               2'b10:   count[v] <= count[v] + 1'b1;
               2'b01:   count[v] <= count[v] - 1'b1;
               default: count[v] <= count[v];
            endcase
         end
         ovf_q <= bus.wr_en && full_vec[bus.vc_in];
         if (load) begin
            data_q <= mem[grant][rd_ptr[grant]];
            vc_q   <= grant;
            val_q  <= 1'b1;
            rr     <= grant;
         end else if (bus.ret) begin
            val_q  <= 1'b0;
         end
      end
   end

   assign bus.full     = full_vec;
   assign bus.ovf      = ovf_q;
   assign bus.Data_out = data_q;
   assign bus.vc_out   = vc_q;
   assign bus.val      = val_q;
endmodule

// File: tb/tb_block_output_vc.sv
// Directed bench for block_output_vc with hand-computed expected link traffic.
module tb_block_output_vc;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   block_output_vc_if #(.DATA_W(8), .NUM_VC(2)) bus ();

   block_output_vc #(.DATA_W(8), .DEPTH(4), .NUM_VC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic vc, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.vc_in   = vc;
      bus.Data_in = d;
   endtask

   task automatic idle();
      bus.wr_en   = 1'b0;
      bus.vc_in   = 1'b0;
      bus.Data_in = 8'h00;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.ret = 1'b0;

      // T1: reset with random inputs
      for (int i = 0; i < 2; i++) begin
         bus.wr_en   = 1'($urandom);
         bus.vc_in   = 1'($urandom);
         bus.Data_in = 8'($urandom);
         bus.ret     = 1'($urandom);
         tick();
      end
      check("t1_val", bus.val, 0);
      check("t1_full", bus.full, 0);
      check("t1_ovf", bus.ovf, 0);
      check("t1_data", bus.Data_out, 0);
      rst = 1'b0;
      idle();
      bus.ret = 1'b1;
      tick();

      // T2: single VC, link always ready
      wr(1'b0, 8'hFA);
      tick();
      check("t2_val_before", bus.val, 0);
      wr(1'b0, 8'hFB);
      tick();
      check("t2_val_fa", bus.val, 1);
      check("t2_data_fa", bus.Data_out, 8'hFA);
      check("t2_vc_fa", bus.vc_out, 0);
      idle();
      tick();
      check("t2_val_fb", bus.val, 1);
      check("t2_data_fb", bus.Data_out, 8'hFB);
      tick();
      check("t2_val_drained", bus.val, 0);
      check("t2_data_kept", bus.Data_out, 8'hFB);

      // T3: backpressure on VC1; the first flit moves into the link register,
      // so the FIFO fills on the 5th write and the 6th is dropped.
      bus.ret = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         wr(1'b1, 8'(i));
         tick();
         if (i == 2) check("t3_first_on_link", bus.Data_out, 8'h01);
         if (i == 4) check("t3_not_full_yet", bus.full, 2'b00);
         if (i == 5) begin
            check("t3_full", bus.full, 2'b10);
            check("t3_no_ovf", bus.ovf, 0);
         end
         if (i == 6) check("t3_ovf", bus.ovf, 1);
      end
      idle();
      tick();
      check("t3_ovf_pulse_end", bus.ovf, 0);
      check("t3_hold_data", bus.Data_out, 8'h01);
      check("t3_hold_val", bus.val, 1);
      check("t3_hold_vc", bus.vc_out, 1);
      bus.ret = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         tick();
         check("t3_stream_val", bus.val, 1);
         check("t3_stream_data", bus.Data_out, 32'(i));
      end
      tick();
      check("t3_drained", bus.val, 0);
      check("t3_full_clear", bus.full, 2'b00);

      // T4: round-robin between VCs
      bus.ret = 1'b0;
      wr(1'b0, 8'hA0); tick();
      wr(1'b0, 8'hA1); tick();
      wr(1'b1, 8'hB0); tick();
      wr(1'b1, 8'hB1); tick();
      idle();
      check("t4_a0", bus.Data_out, 8'hA0);
      check("t4_a0_vc", bus.vc_out, 0);
      bus.ret = 1'b1;
      tick();
      check("t4_b0", bus.Data_out, 8'hB0);
      check("t4_b0_vc", bus.vc_out, 1);
      tick();
      check("t4_a1", bus.Data_out, 8'hA1);
      check("t4_a1_vc", bus.vc_out, 0);
      tick();
      check("t4_b1", bus.Data_out, 8'hB1);
      check("t4_b1_vc", bus.vc_out, 1);
      tick();
      check("t4_drained", bus.val, 0);

      // T5: write to a full VC in the same cycle it is popped
      bus.ret = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr(1'b0, 8'(8'h10 + i));
         tick();
      end
      check("t5_full", bus.full, 2'b01);
      bus.ret = 1'b1;
      wr(1'b0, 8'h55);
      tick();
      idle();
      check("t5_ovf", bus.ovf, 1);
      check("t5_full_drop", bus.full, 2'b00);
      check("t5_data_11", bus.Data_out, 8'h11);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check("t5_stream_data", bus.Data_out, 32'(8'h10 + i));
         check("t5_stream_val", bus.val, 1);
      end
      check("t5_ovf_end", bus.ovf, 0);
      tick();
      check("t5_drained_no_55", bus.val, 0);

      // T6: reset in mid-operation
      bus.ret = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, 8'(8'h21 + i));
         tick();
      end
      check("t6_val_busy", bus.val, 1);
      wr(1'b0, 8'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      check("t6_val", bus.val, 0);
      check("t6_full", bus.full, 0);
      check("t6_data", bus.Data_out, 0);
      check("t6_vc", bus.vc_out, 0);
      bus.ret = 1'b1;
      wr(1'b1, 8'h99);
      tick();
      idle();
      tick();
      check("t6_fresh_val", bus.val, 1);
      check("t6_fresh_data", bus.Data_out, 8'h99);
      check("t6_fresh_vc", bus.vc_out, 1);
      tick();
      check("t6_no_stale", bus.val, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
